// File: rtl/timed_ram_pkg.sv
// rtl/timed_ram_pkg.sv - shared memory-port widths, FSM states and helpers for timed_ram
package timed_ram_pkg;
  localparam int MEM_ADDR_W = 64;
  localparam int MEM_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_RD = 2'd1,
    BUSY_WR = 2'd2
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/timed_ram_sat_counter.sv
// rtl/timed_ram_sat_counter.sv - saturating event counter with async active-low clear
// Present only when TIMED_RAM_STATS_EN is defined.
`ifdef TIMED_RAM_STATS_EN
module timed_ram_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;
endmodule
`endif

// File: rtl/timed_ram.sv
// rtl/timed_ram.sv - word-addressed backing RAM with programmable read/write latency
// Optional rd_count/wr_count statistics ports under TIMED_RAM_STATS_EN.
module timed_ram
  import timed_ram_pkg::*;
#(
  parameter int ADDR_BITS     = 10,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MEM_ADDR_W-1:0] addr,
  input  logic [MEM_DATA_W-1:0] din,
  output logic [MEM_DATA_W-1:0] dout,
  input  logic                  re,
  input  logic                  we,
  output logic                  ready
`ifdef TIMED_RAM_STATS_EN
  ,
  output logic [31:0]           rd_count,
  output logic [31:0]           wr_count
`endif
);
  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int CNT_W = $clog2(max_int(READ_LATENCY, WRITE_LATENCY)) + 1;

  logic [MEM_DATA_W-1:0] mem [DEPTH];

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic [MEM_DATA_W-1:0] dout_q, dout_d;
  logic [MEM_DATA_W-1:0] rdata_q, rdata_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [ADDR_BITS-1:0]  idx;
  logic                  wr_accept;
  logic                  unused_addr_hi;

  // Upper address bits alias onto the same word.
  assign idx            = addr[ADDR_BITS-1:0];
  assign unused_addr_hi = ^addr[MEM_ADDR_W-1:ADDR_BITS];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ready_d   = ready_q;
    dout_d    = dout_q;
    rdata_d   = rdata_q;
    valid_d   = valid_q;
    wr_accept = 1'b0;
    case (state_q)
      IDLE: begin
        if (we) begin
          wr_accept    = 1'b1;
          valid_d[idx] = 1'b1;
          ready_d      = 1'b0;
          cnt_d        = CNT_W'(WRITE_LATENCY - 1);
          state_d      = BUSY_WR;
        end else if (re) begin
          rdata_d = valid_q[idx] ? mem[idx] : {MEM_DATA_W{1'b1}};
          ready_d = 1'b0;
          cnt_d   = CNT_W'(READ_LATENCY - 1);
          state_d = BUSY_RD;
        end
      end
      BUSY_RD, BUSY_WR: begin
        if (cnt_q == '0) begin
          ready_d = 1'b1;
          if (state_q == BUSY_RD) dout_d = rdata_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      dout_q  <= '0;
      rdata_q <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
    end
  end

  // Storage is never cleared; only the valid bits are reset.
  always_ff @(posedge clk) begin
    if (wr_accept && rst) mem[idx] <= din;
  end

  assign dout  = dout_q;
  assign ready = ready_q;

`ifdef TIMED_RAM_STATS_EN
  logic rd_done, wr_done;
  assign rd_done = (state_q == BUSY_RD) && (cnt_q == '0);
  assign wr_done = (state_q == BUSY_WR) && (cnt_q == '0);

  timed_ram_sat_counter #(.WIDTH(32)) u_rd_count (
    .clk  (clk),
    .clr_n(rst),
    .inc  (rd_done),
    .count(rd_count)
  );

  timed_ram_sat_counter #(.WIDTH(32)) u_wr_count (
    .clk  (clk),
    .clr_n(rst),
    .inc  (wr_done),
    .count(wr_count)
  );
`endif
endmodule

// File: tb/tb_timed_ram.sv
// tb/tb_timed_ram.sv - self-checking bench for timed_ram against an array reference model
// Checks rd_count/wr_count as well when TIMED_RAM_STATS_EN is defined.
module tb_timed_ram;
  localparam int AB    = 8;
  localparam int RL    = 4;
  localparam int WL    = 3;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] addr = '0;
  logic [63:0] din = '0;
  logic        re = 1'b0;
  logic        we = 1'b0;
  logic [63:0] dout;
  logic        ready;
`ifdef TIMED_RAM_STATS_EN
  logic [31:0] rd_count, wr_count;
`endif

  int total  = 0;
  int passed = 0;

  logic [63:0] mmem [DEPTH];
  bit          mvalid [DEPTH];
  logic [63:0] mdout = '0;
  int unsigned mrd = 0;
  int unsigned mwr = 0;

  timed_ram #(
    .ADDR_BITS    (AB),
    .READ_LATENCY (RL),
    .WRITE_LATENCY(WL)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .addr (addr),
    .din  (din),
    .dout (dout),
    .re   (re),
    .we   (we),
    .ready(ready)
`ifdef TIMED_RAM_STATS_EN
    ,
    .rd_count(rd_count),
    .wr_count(wr_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle_ready", 64'(ready), 64'd1);
  endtask

  task automatic model_reset();
    foreach (mvalid[i]) mvalid[i] = 1'b0;
    mdout = '0;
    mrd   = 0;
    mwr   = 0;
  endtask

  // One access; junk=1 drives random requests while busy, which must be ignored.
  task automatic do_op(input logic [63:0] a, input logic [63:0] d, input logic r,
                       input logic w, input bit junk);
    int busy;
    int idx;
    wait_ready();
    addr = a;
    din  = d;
    re   = r;
    we   = w;
    @(negedge clk);
    idx = int'(a % DEPTH);
    if (w) begin
      mmem[idx]   = d;
      mvalid[idx] = 1'b1;
    end else if (r) begin
      mdout = mvalid[idx] ? mmem[idx] : 64'hFFFF_FFFF_FFFF_FFFF;
    end
    busy = 0;
    while (ready === 1'b0 && busy < 100) begin
      busy++;
      if (junk) begin
        addr = {$urandom, $urandom};
        din  = {$urandom, $urandom};
        re   = 1'($urandom_range(0, 1));
        we   = 1'($urandom_range(0, 1));
      end else begin
        re = 1'b0;
        we = 1'b0;
      end
      @(negedge clk);
    end
    re = 1'b0;
    we = 1'b0;
    if (w) mwr++;
    else   mrd++;
    check(w ? "wr_busy_cycles" : "rd_busy_cycles", 64'(busy), 64'(w ? WL : RL));
    check(w ? "dout_after_wr" : "dout_after_rd", dout, mdout);
`ifdef TIMED_RAM_STATS_EN
    check("rd_count", 64'(rd_count), 64'(mrd));
    check("wr_count", 64'(wr_count), 64'(mwr));
`endif
  endtask

  initial begin
    logic [63:0] a, d;
    int op;
    model_reset();

    repeat (2) @(negedge clk);
    check("reset_ready", 64'(ready), 64'd1);
    check("reset_dout", dout, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_ready", 64'(ready), 64'd1);
    check("post_reset_dout", dout, 64'd0);

    do_op(64'd0, 64'd0, 1'b1, 1'b0, 1'b0);
    check("unwritten_all_ones", dout, 64'hFFFF_FFFF_FFFF_FFFF);

    do_op(64'd1, 64'h0123456789abcdef, 1'b0, 1'b1, 1'b0);
    do_op(64'd1, 64'd0, 1'b1, 1'b0, 1'b0);
    check("read_back_1", dout, 64'h0123456789abcdef);

    do_op(64'd257, 64'd123, 1'b0, 1'b1, 1'b0);
    do_op(64'd1, 64'd5, 1'b0, 1'b1, 1'b0);
    do_op(64'd257, 64'd0, 1'b1, 1'b0, 1'b0);
    check("alias_257", dout, 64'd5);
    do_op(64'd256, 64'd321, 1'b0, 1'b1, 1'b0);
    do_op(64'd256, 64'd0, 1'b1, 1'b0, 1'b0);
    check("alias_256", dout, 64'd321);

    do_op(64'd3, 64'd7, 1'b1, 1'b1, 1'b0);
    check("re_we_dout_held", dout, 64'd321);
    do_op(64'd3, 64'd0, 1'b1, 1'b0, 1'b0);
    check("re_we_was_write", dout, 64'd7);

    for (int i = 0; i < 150; i++) begin
      a  = 64'($urandom_range(0, 1023));
      d  = {$urandom, $urandom};
      op = int'($urandom_range(0, 2));
      do_op(a, d, op != 0, op != 1, 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    wait_ready();
    addr = 64'd9;
    din  = 64'd42;
    we   = 1'b1;
    @(negedge clk);
    we = 1'b0;
    mmem[9] = 64'd42;
    check("t6_busy", 64'(ready), 64'd0);
    #2 rst = 1'b0;
    #1;
    check("t6_async_ready", 64'(ready), 64'd1);
    check("t6_async_dout", dout, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    do_op(64'd9, 64'd0, 1'b1, 1'b0, 1'b0);
    check("t6_read_invalid", dout, 64'hFFFF_FFFF_FFFF_FFFF);
`ifdef TIMED_RAM_STATS_EN
    check("t6_rd_count", 64'(rd_count), 64'd1);
    check("t6_wr_count", 64'(wr_count), 64'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
